// File: rtl/sequenciador_frota_pkg.sv
// Shared definitions for the fleet-setup sequencer: ship type codes,
// default fleet composition and the sequencer state encoding.
package sequenciador_frota_pkg;

    localparam logic [2:0] TIPO_NENHUM = 3'd0;
    localparam logic [2:0] TIPO_SUB    = 3'd1;
    localparam logic [2:0] TIPO_CRUZ   = 3'd2;
    localparam logic [2:0] TIPO_HIDRO  = 3'd3;
    localparam logic [2:0] TIPO_ENC    = 3'd4;
    localparam logic [2:0] TIPO_PORTA  = 3'd5;

    localparam int N_SUB_DEF   = 5;
    localparam int N_CRUZ_DEF  = 2;
    localparam int N_HIDRO_DEF = 2;
    localparam int N_ENC_DEF   = 1;
    localparam int N_PORTA_DEF = 1;

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        CARREGA   = 3'd1,
        AGUARDA   = 3'd2,
        AVANCA    = 3'd3,
        TROCA_JOG = 3'd4,
        FIM       = 3'd5
    } estado_t;

    function automatic int total_frota(input int a, input int b, input int c,
                                       input int d, input int e);
        return a + b + c + d + e;
    endfunction

endpackage

// File: rtl/sequenciador_frota_tipo_lut.sv
// Maps a piece index within one fleet to its ship type using cumulative
// thresholds of the per-type counts; indices past the fleet map to none.
module frota_tipo_lut
    import sequenciador_frota_pkg::*;
#(
    parameter int N_SUB   = N_SUB_DEF,
    parameter int N_CRUZ  = N_CRUZ_DEF,
    parameter int N_HIDRO = N_HIDRO_DEF,
    parameter int N_ENC   = N_ENC_DEF,
    parameter int N_PORTA = N_PORTA_DEF
) (
    input  logic [3:0] indice,
    output logic [2:0] tipo
);

    localparam logic [3:0] LIM_SUB   = 4'(N_SUB);
    localparam logic [3:0] LIM_CRUZ  = 4'(N_SUB + N_CRUZ);
    localparam logic [3:0] LIM_HIDRO = 4'(N_SUB + N_CRUZ + N_HIDRO);
    localparam logic [3:0] LIM_ENC   = 4'(N_SUB + N_CRUZ + N_HIDRO + N_ENC);
    localparam logic [3:0] LIM_PORTA = 4'(total_frota(N_SUB, N_CRUZ, N_HIDRO, N_ENC, N_PORTA));

    always_comb begin
        tipo = TIPO_NENHUM;
        if (indice < LIM_SUB)        tipo = TIPO_SUB;
        else if (indice < LIM_CRUZ)  tipo = TIPO_CRUZ;
        else if (indice < LIM_HIDRO) tipo = TIPO_HIDRO;
        else if (indice < LIM_ENC)   tipo = TIPO_ENC;
        else if (indice < LIM_PORTA) tipo = TIPO_PORTA;
    end

endmodule

// File: rtl/sequenciador_frota.sv
// Walks the piece placer through both players' fleets in fixed type order,
// retrying rejected pieces and flagging completion of the whole setup.
module sequenciador_frota
    import sequenciador_frota_pkg::*;
#(
    parameter int N_SUB   = N_SUB_DEF,
    parameter int N_CRUZ  = N_CRUZ_DEF,
    parameter int N_HIDRO = N_HIDRO_DEF,
    parameter int N_ENC   = N_ENC_DEF,
    parameter int N_PORTA = N_PORTA_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       modo,
    input  logic       peca_pronta,
    input  logic       peca_valida,
    output logic       habilita_pos,
    output logic [2:0] tipo,
    output logic       jogador,
    output logic       fonte_cpu,
    output logic [3:0] indice_peca,
    output logic       erro_conflito,
    output logic       fim_posicionamento
);

    localparam int         TOTAL  = total_frota(N_SUB, N_CRUZ, N_HIDRO, N_ENC, N_PORTA);
    localparam logic [3:0] ULTIMO = 4'(TOTAL - 1);

    estado_t    estado, estado_n;
    logic [3:0] indice_n;
    logic [2:0] tipo_n, tipo_lut;
    logic       jogador_n, modo_lat, modo_lat_n, erro_n;

    frota_tipo_lut #(
        .N_SUB  (N_SUB),
        .N_CRUZ (N_CRUZ),
        .N_HIDRO(N_HIDRO),
        .N_ENC  (N_ENC),
        .N_PORTA(N_PORTA)
    ) u_lut (
        .indice(indice_peca),
        .tipo  (tipo_lut)
    );

    always_comb begin
        estado_n   = estado;
        indice_n   = indice_peca;
        jogador_n  = jogador;
        modo_lat_n = modo_lat;
        tipo_n     = tipo;
        erro_n     = 1'b0;
        case (estado)
            OCIOSO, FIM: begin
                if (iniciar) begin
                    estado_n   = CARREGA;
                    jogador_n  = 1'b0;
                    indice_n   = '0;
                    modo_lat_n = modo;
                end
            end
            CARREGA: begin
                tipo_n   = tipo_lut;
                estado_n = AGUARDA;
            end
            AGUARDA: begin
                if (peca_pronta) begin
                    if (peca_valida) estado_n = AVANCA;
                    else             erro_n   = 1'b1;
                end
            end
            AVANCA: begin
                if (indice_peca == ULTIMO) begin
                    estado_n = jogador ? FIM : TROCA_JOG;
                end else begin
                    indice_n = indice_peca + 4'd1;
                    estado_n = CARREGA;
                end
            end
            TROCA_JOG: begin
                jogador_n = 1'b1;
                indice_n  = '0;
                estado_n  = CARREGA;
            end
            default: estado_n = OCIOSO;
        endcase
        if (estado_n == FIM) tipo_n = TIPO_NENHUM;
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado             <= OCIOSO;
            indice_peca        <= '0;
            jogador            <= 1'b0;
            modo_lat           <= 1'b0;
            tipo               <= TIPO_NENHUM;
            erro_conflito      <= 1'b0;
            habilita_pos       <= 1'b0;
            fim_posicionamento <= 1'b0;
        end else begin
            estado             <= estado_n;
            indice_peca        <= indice_n;
            jogador            <= jogador_n;
            modo_lat           <= modo_lat_n;
            tipo               <= tipo_n;
            erro_conflito      <= erro_n;
            habilita_pos       <= (estado_n == AGUARDA);
            fim_posicionamento <= (estado_n == FIM);
        end
    end

    assign fonte_cpu = modo_lat & jogador;

endmodule

// File: tb/tb_sequenciador_frota.sv
// Directed bench for the fleet-setup sequencer with hand-computed expectations.
module tb_sequenciador_frota;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0, modo = 1'b0, peca_pronta = 1'b0, peca_valida = 1'b0;
    logic       habilita_pos, jogador, fonte_cpu, erro_conflito, fim_posicionamento;
    logic [2:0] tipo;
    logic [3:0] indice_peca;

    int n_cmp = 0;
    int n_err = 0;
    int tt[11] = '{1, 1, 1, 1, 1, 2, 2, 3, 3, 4, 5};

    sequenciador_frota dut (
        .clk               (clk),
        .reset             (reset),
        .iniciar           (iniciar),
        .modo              (modo),
        .peca_pronta       (peca_pronta),
        .peca_valida       (peca_valida),
        .habilita_pos      (habilita_pos),
        .tipo              (tipo),
        .jogador           (jogador),
        .fonte_cpu         (fonte_cpu),
        .indice_peca       (indice_peca),
        .erro_conflito     (erro_conflito),
        .fim_posicionamento(fim_posicionamento)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ticks until habilita_pos or fim rises; n counts the tick already taken
    task automatic wait_evt(output int n);
        n = 1;
        while (!(habilita_pos || fim_posicionamento) && n < 12) begin
            tick();
            n++;
        end
    endtask

    task automatic pronta(input logic v);
        peca_pronta = 1'b1;
        peca_valida = v;
        tick();
        peca_pronta = 1'b0;
        peca_valida = 1'b0;
    endtask

    task automatic start(input logic m);
        int n;
        iniciar = 1'b1;
        modo    = m;
        tick();
        iniciar = 1'b0;
        chk("ini_hab_t1", int'(habilita_pos), 0);
        chk("ini_fim_clr", int'(fim_posicionamento), 0);
        wait_evt(n);
        chk("lat_ini", n, 2);
        chk("ini_jog", int'(jogador), 0);
        chk("ini_idx", int'(indice_peca), 0);
    endtask

    task automatic frota(input logic cpu);
        int n, lat;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 11; i++) begin
                chk("tipo", int'(tipo), tt[i]);
                chk("idx", int'(indice_peca), i);
                chk("jog", int'(jogador), p);
                chk("fonte_cpu", int'(fonte_cpu), (cpu && p == 1) ? 1 : 0);
                pronta(1'b1);
                chk("hab_u1", int'(habilita_pos), 0);
                wait_evt(n);
                lat = (i < 10) ? 3 : ((p == 0) ? 4 : 2);
                chk("lat_pronta", n, lat);
            end
        end
        chk("fim", int'(fim_posicionamento), 1);
        chk("fim_tipo", int'(tipo), 0);
        chk("fim_hab", int'(habilita_pos), 0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_hab", int'(habilita_pos), 0);
        chk("rst_fim", int'(fim_posicionamento), 0);
        chk("rst_tipo", int'(tipo), 0);
        reset = 1'b1;
        tick();

        // happy path, player vs player
        start(1'b0);
        frota(1'b0);

        // restart from FIM, then conflict at indice 6
        start(1'b0);
        for (int i = 0; i < 6; i++) begin
            int n;
            pronta(1'b1);
            wait_evt(n);
        end
        chk("c_idx6", int'(indice_peca), 6);
        chk("c_tipo2", int'(tipo), 2);
        pronta(1'b0);
        chk("c_erro", int'(erro_conflito), 1);
        chk("c_hab", int'(habilita_pos), 1);
        chk("c_idx_keep", int'(indice_peca), 6);
        tick();
        chk("c_erro_once", int'(erro_conflito), 0);
        chk("c_tipo_keep", int'(tipo), 2);
        begin
            int n;
            pronta(1'b1);
            wait_evt(n);
            chk("c_lat", n, 3);
        end
        chk("c_idx7", int'(indice_peca), 7);
        chk("c_tipo3", int'(tipo), 3);

        // pronta during CARREGA is ignored
        pronta(1'b1);
        tick();
        peca_pronta = 1'b1;
        peca_valida = 1'b1;
        tick();
        peca_pronta = 1'b0;
        peca_valida = 1'b0;
        chk("sp_idx8", int'(indice_peca), 8);
        chk("sp_hab", int'(habilita_pos), 1);
        tick();
        chk("sp_idx_keep", int'(indice_peca), 8);
        chk("sp_hab_keep", int'(habilita_pos), 1);

        // valida alone and iniciar in AGUARDA are ignored
        peca_valida = 1'b1;
        tick();
        peca_valida = 1'b0;
        chk("sp_val_hab", int'(habilita_pos), 1);
        chk("sp_val_idx", int'(indice_peca), 8);
        iniciar = 1'b1;
        modo    = 1'b1;
        tick();
        iniciar = 1'b0;
        chk("sp_ini_idx", int'(indice_peca), 8);
        chk("sp_ini_hab", int'(habilita_pos), 1);
        chk("sp_ini_tipo", int'(tipo), 3);

        // asynchronous reset mid-fleet
        #2;
        reset = 1'b0;
        #1;
        chk("ar_hab", int'(habilita_pos), 0);
        chk("ar_idx", int'(indice_peca), 0);
        chk("ar_tipo", int'(tipo), 0);
        chk("ar_jog", int'(jogador), 0);
        chk("ar_erro", int'(erro_conflito), 0);
        chk("ar_fim", int'(fim_posicionamento), 0);
        tick();
        reset = 1'b1;
        tick();
        chk("ar_post_hab", int'(habilita_pos), 0);
        chk("ar_post_fim", int'(fim_posicionamento), 0);

        // player vs CPU; later modo changes have no effect
        start(1'b1);
        modo = 1'b0;
        frota(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
